// File: rtl/conv_pkg.sv
// Shared definitions for the conv writeback path: default widths, sink FSM
// states and the result FIFO entry layout {lane, last, data}.
package conv_pkg;

    localparam int CONV_DATA_W = 25;
    localparam int CONV_DEPTH  = 61;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sink_state_e;

    // Entry layout: lane at the top, the row-end marker below it, then the data.
    function automatic int entry_w(input int out_w);
        return out_w + 2;
    endfunction

    function automatic int entry_lane_bit(input int out_w);
        return out_w + 1;
    endfunction

    function automatic int entry_last_bit(input int out_w);
        return out_w;
    endfunction

endpackage

// File: rtl/result_fifo_2w1r.sv
// Synchronous FIFO with two write ports (port 0 lands first) and one read port.
// Head is read combinationally; occupancy after this cycle is exported for stall.
module result_fifo_2w1r #(
    parameter int ENTRY_W    = 34,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    wr_en,
    input  logic [ENTRY_W-1:0]            wr_data0,
    input  logic [ENTRY_W-1:0]            wr_data1,
    input  logic                          rd_en,
    output logic [ENTRY_W-1:0]            rd_data,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count_next
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [AW-1:0]      wr_ptr_inc;
    logic [AW:0]        count_reg;
    logic [AW:0]        n_wr;
    logic               rd_fire;

    assign empty      = (count_reg == '0);
    assign rd_fire    = rd_en & ~empty;
    assign wr_ptr_inc = wr_ptr_reg + AW'(1);
    assign n_wr       = (AW+1)'(wr_en[0]) + (AW+1)'(wr_en[1]);
    assign count_next = count_reg + n_wr - (AW+1)'(rd_fire);
    assign rd_data    = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + n_wr[AW-1:0];
            if (rd_fire) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    // Lane 1 takes the slot after lane 0 only when both write together.
    always_ff @(posedge clk) begin
        if (wr_en[0]) begin
            mem[wr_ptr_reg] <= wr_data0;
        end
        if (wr_en[1]) begin
            mem[wr_en[0] ? wr_ptr_inc : wr_ptr_reg] <= wr_data1;
        end
    end

endmodule

// File: rtl/conv_result_sink.sv
// Receiving end of the conv writeback interface: buffers both result lanes,
// back-pressures the producer and serialises sign-extended results onto one stream.
module conv_result_sink
    import conv_pkg::*;
#(
    parameter int DATA_W     = CONV_DATA_W,
    parameter int DEPTH      = CONV_DEPTH,
    parameter int FIFO_DEPTH = 8,
    parameter int OUT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] port0,
    input  logic              port0_valid,
    input  logic [DATA_W-1:0] port1,
    input  logic              port1_valid,
    input  logic              end_op,
    output logic              stall,
    output logic [OUT_W-1:0]  m_tdata,
    output logic              m_tuser,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              op_done,
    output logic              err,
    output logic [15:0]       result_cnt
);

    localparam int ENTRY_W  = entry_w(OUT_W);
    localparam int LANE_BIT = entry_lane_bit(OUT_W);
    localparam int LAST_BIT = entry_last_bit(OUT_W);
    localparam int CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);

    sink_state_e        state_reg, state_next;
    logic               stall_reg, stall_next;
    logic               err_reg, err_next;
    logic [15:0]        result_cnt_reg, result_cnt_next;

    logic [1:0]         lane_valid;
    logic [1:0]         push;
    logic [DATA_W-1:0]  lane_in [2];
    logic [ENTRY_W-1:0] lane_entry [2];
    logic [ENTRY_W-1:0] head;
    logic               fifo_empty;
    logic [AW:0]        fifo_count_next;
    logic               accept_any;
    logic               eop;

    assign lane_valid = {port1_valid, port0_valid};
    assign lane_in[0] = port0;
    assign lane_in[1] = port1;
    // While stalled the producer is frozen, so nothing on its outputs is sampled.
    assign push       = lane_valid & {2{~stall_reg}};
    assign accept_any = |push;
    assign eop        = end_op & ~stall_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [CW-1:0]           cnt_reg;
            logic                    last;
            logic signed [OUT_W-1:0] sext;

            assign last           = (cnt_reg == CW'(DEPTH - 1));
            assign sext           = OUT_W'($signed(lane_in[gi]));
            assign lane_entry[gi] = {1'(gi), last, sext};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (state_reg == DONE) begin
                    cnt_reg <= '0;
                end else if (push[gi]) begin
                    cnt_reg <= last ? '0 : cnt_reg + CW'(1);
                end
            end
        end
    endgenerate

    result_fifo_2w1r #(
        .ENTRY_W   (ENTRY_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (push),
        .wr_data0  (lane_entry[0]),
        .wr_data1  (lane_entry[1]),
        .rd_en     (m_tready),
        .rd_data   (head),
        .empty     (fifo_empty),
        .count_next(fifo_count_next)
    );

    // Storage is not reset, so the stream fields are forced to 0 while empty.
    assign m_tvalid   = ~fifo_empty;
    assign m_tdata    = fifo_empty ? '0 : head[OUT_W-1:0];
    assign m_tuser    = ~fifo_empty & head[LANE_BIT];
    assign m_tlast    = ~fifo_empty & head[LAST_BIT];
    assign stall      = stall_reg;
    assign op_done    = (state_reg == DONE);
    assign err        = err_reg;
    assign result_cnt = result_cnt_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (eop) begin
                    state_next = DRAIN;
                end else if (accept_any) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (eop) begin
                    state_next = DRAIN;
                end
            end
            // Leave as soon as this cycle's pop empties the FIFO.
            DRAIN: begin
                if (fifo_count_next == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall_next = (fifo_count_next > (AW+1)'(FIFO_DEPTH - 2));
        err_next   = err_reg
                   | (port1_valid & ~port0_valid & ~stall_reg)
                   | (accept_any & ((state_reg == DRAIN) || (state_reg == DONE)))
                   | (eop & accept_any);
        if (state_reg == DONE) begin
            result_cnt_next = '0;
        end else begin
            result_cnt_next = result_cnt_reg + 16'(push[0]) + 16'(push[1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            stall_reg      <= 1'b0;
            err_reg        <= 1'b0;
            result_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            stall_reg      <= stall_next;
            err_reg        <= err_next;
            result_cnt_reg <= result_cnt_next;
        end
    end

endmodule

// File: tb/tb_conv_result_sink.sv
// Directed bench for conv_result_sink with DEPTH=4, FIFO_DEPTH=8: per-cycle vector
// tables for the paired burst and single-lane drain, hand sequences for the rest.
module tb_conv_result_sink;

    logic        clk;
    logic        rst_n;
    logic [24:0] port0;
    logic        port0_valid;
    logic [24:0] port1;
    logic        port1_valid;
    logic        end_op;
    logic        stall;
    logic [31:0] m_tdata;
    logic        m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        op_done;
    logic        err;
    logic [15:0] result_cnt;

    int total;
    int bad;

    conv_result_sink #(
        .DATA_W    (25),
        .DEPTH     (4),
        .FIFO_DEPTH(8),
        .OUT_W     (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .port0      (port0),
        .port0_valid(port0_valid),
        .port1      (port1),
        .port1_valid(port1_valid),
        .end_op     (end_op),
        .stall      (stall),
        .m_tdata    (m_tdata),
        .m_tuser    (m_tuser),
        .m_tlast    (m_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .op_done    (op_done),
        .err        (err),
        .result_cnt (result_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        p0v;
        logic [24:0] p0;
        logic        p1v;
        logic [24:0] p1;
        logic        eop;
        logic        rdy;
        logic        e_tv;
        logic [31:0] e_data;
        logic        e_user;
        logic        e_last;
        logic        e_opdone;
        logic [15:0] e_rc;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
    } out_t;

    vec_t vecs[$];
    out_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic p0v, input logic [24:0] p0, input logic p1v,
                       input logic [24:0] p1, input logic eop, input logic rdy,
                       input logic tv, input logic [31:0] data, input logic user,
                       input logic last, input logic opd, input logic [15:0] rc);
        vec_t v;
        v.p0v = p0v; v.p0 = p0; v.p1v = p1v; v.p1 = p1; v.eop = eop; v.rdy = rdy;
        v.e_tv = tv; v.e_data = data; v.e_user = user; v.e_last = last;
        v.e_opdone = opd; v.e_rc = rc;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        port0_valid = 1'b0;
        port1_valid = 1'b0;
        end_op      = 1'b0;
    endtask

    // Pops every queued expectation through the stream, bounded by budget cycles.
    task automatic drain(input int budget);
        out_t e;
        idle_inputs();
        m_tready = 1'b1;
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (m_tvalid) begin
                e = exp_q.pop_front();
                chk("drain_tdata", m_tdata, e.data);
                chk("drain_tuser", 32'(m_tuser), 32'(e.user));
                chk("drain_tlast", 32'(m_tlast), 32'(e.last));
                $display("out: tdata=%h lane=%0b last=%0b", m_tdata, m_tuser, m_tlast);
            end
            @(posedge clk);
            #1;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (op_done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("op_done_seen", 32'(seen), 32'd1);
        if (seen) begin
            $display("op_done observed");
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("op_done_single", 32'(op_done), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_op();
        idle_inputs();
        m_tready = 1'b1;
        end_op   = 1'b1;
        @(posedge clk);
        #1;
        end_op = 1'b0;
        wait_done(10);
    endtask

    initial begin
        vec_t v;
        int   val;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        port0 = '0;
        port1 = '0;
        m_tready = 1'b0;
        idle_inputs();

        // Paired burst: values 1..8 in lane order, row ends on 7 and 8.
        add(1, 1, 1, 2, 0, 1,  0, 0, 0, 0, 0, 0);
        add(1, 3, 1, 4, 0, 1,  1, 1, 0, 0, 0, 2);
        add(1, 5, 1, 6, 0, 1,  1, 2, 1, 0, 0, 4);
        add(1, 7, 1, 8, 0, 1,  1, 3, 0, 0, 0, 6);
        add(0, 0, 0, 0, 1, 1,  1, 4, 1, 0, 0, 8);
        add(0, 0, 0, 0, 0, 1,  1, 5, 0, 0, 0, 8);
        add(0, 0, 0, 0, 0, 1,  1, 6, 1, 0, 0, 8);
        add(0, 0, 0, 0, 0, 1,  1, 7, 0, 1, 0, 8);
        add(0, 0, 0, 0, 0, 1,  1, 8, 1, 1, 0, 8);
        add(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 8);
        add(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        // Single lane, 5 results held in the FIFO, then end_op and drain.
        add(1, 100, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0);
        add(1, 101, 0, 0, 0, 0,  1, 100, 0, 0, 0, 1);
        add(1, 102, 0, 0, 0, 0,  1, 100, 0, 0, 0, 2);
        add(1, 103, 0, 0, 0, 0,  1, 100, 0, 0, 0, 3);
        add(1, 104, 0, 0, 0, 0,  1, 100, 0, 0, 0, 4);
        add(0, 0,   0, 0, 1, 0,  1, 100, 0, 0, 0, 5);
        add(0, 0,   0, 0, 0, 1,  1, 100, 0, 0, 0, 5);
        add(0, 0,   0, 0, 0, 1,  1, 101, 0, 0, 0, 5);
        add(0, 0,   0, 0, 0, 1,  1, 102, 0, 0, 0, 5);
        add(0, 0,   0, 0, 0, 1,  1, 103, 0, 1, 0, 5);
        add(0, 0,   0, 0, 0, 1,  1, 104, 0, 0, 0, 5);
        add(0, 0,   0, 0, 0, 1,  0, 0,   0, 0, 1, 5);
        add(0, 0,   0, 0, 0, 1,  0, 0,   0, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_op_done", 32'(op_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result_cnt", 32'(result_cnt), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tuser_tlast", {30'd0, m_tuser, m_tlast}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            port0_valid = v.p0v;
            port0       = v.p0;
            port1_valid = v.p1v;
            port1       = v.p1;
            end_op      = v.eop;
            m_tready    = v.rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_tvalid", i), 32'(m_tvalid), 32'(v.e_tv));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
            chk($sformatf("vec%0d_op_done", i), 32'(op_done), 32'(v.e_opdone));
            chk($sformatf("vec%0d_result_cnt", i), 32'(result_cnt), 32'(v.e_rc));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'd0);
            if (v.e_tv) begin
                chk($sformatf("vec%0d_tdata", i), m_tdata, v.e_data);
                chk($sformatf("vec%0d_tuser", i), 32'(m_tuser), 32'(v.e_user));
                chk($sformatf("vec%0d_tlast", i), 32'(m_tlast), 32'(v.e_last));
            end
            $display("vec %0d: tvalid=%0b tdata=%h lane=%0b last=%0b op_done=%0b cnt=%0d",
                     i, m_tvalid, m_tdata, m_tuser, m_tlast, op_done, result_cnt);
            @(posedge clk);
            #1;
        end
        idle_inputs();

        // Sign extension of a negative and of the largest positive lane value.
        m_tready = 1'b0;
        port0_valid = 1'b1;
        port0 = 25'h1FFFFFF;
        @(posedge clk);
        #1;
        port0 = 25'h0FFFFFF;
        m_tready = 1'b1;
        @(negedge clk);
        chk("sext_neg", m_tdata, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        port0_valid = 1'b0;
        @(negedge clk);
        chk("sext_pos", m_tdata, 32'h00FFFFFF);
        chk("sext_pos_last", 32'(m_tlast), 32'd0);
        $display("sext: tdata=%h", m_tdata);
        @(posedge clk);
        #1;
        finish_op();

        // Back-pressure: downstream blocked, producer offers pairs every cycle.
        m_tready = 1'b0;
        val = 1;
        for (int k = 0; k < 6; k++) begin
            port0_valid = 1'b1;
            port1_valid = 1'b1;
            port0 = 25'(val);
            port1 = 25'(val + 1);
            @(negedge clk);
            chk($sformatf("bp_stall%0d", k), 32'(stall), (k >= 4) ? 32'd1 : 32'd0);
            $display("bp cycle %0d: stall=%0b", k, stall);
            if (k < 4) begin
                exp_q.push_back('{data: 32'(val), user: 1'b0, last: (k == 3)});
                exp_q.push_back('{data: 32'(val + 1), user: 1'b1, last: (k == 3)});
                val += 2;
            end
            @(posedge clk);
            #1;
        end
        drain(30);
        @(negedge clk);
        chk("bp_no_extra", 32'(m_tvalid), 32'd0);
        chk("bp_stall_released", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        finish_op();

        // Protocol error: lane 1 without lane 0.
        port1_valid = 1'b1;
        port1 = 25'd42;
        m_tready = 1'b1;
        @(negedge clk);
        chk("err_before", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("err_p1_only", 32'(err), 32'd1);
        chk("err_p1_tdata", m_tdata, 32'd42);
        chk("err_p1_tuser", 32'(m_tuser), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("err_sticky_a", 32'(err), 32'd1);
        @(posedge clk);
        #1;

        // Fill 5 entries, then reset in the middle of the operation.
        m_tready = 1'b0;
        port0_valid = 1'b1; port0 = 25'd1; port1_valid = 1'b1; port1 = 25'd2;
        @(posedge clk);
        #1;
        port0 = 25'd3; port1 = 25'd4;
        @(posedge clk);
        #1;
        port0 = 25'd5; port1_valid = 1'b0;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("pre_rst_tvalid", 32'(m_tvalid), 32'd1);
        chk("pre_rst_cnt", 32'(result_cnt), 32'd6);
        chk("err_sticky_b", 32'(err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_cnt", 32'(result_cnt), 32'd0);
        $display("reset asserted mid-operation");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("mid_rst_op_done", 32'(op_done), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("post_rst_op_done", 32'(op_done), 32'd0);
        @(posedge clk);
        #1;

        // Clean restart: lane-0 row end must land on the 4th result.
        for (int k = 0; k < 4; k++) begin
            port0_valid = 1'b1;
            port0 = 25'(7 + k);
            exp_q.push_back('{data: 32'(7 + k), user: 1'b0, last: (k == 3)});
            @(posedge clk);
            #1;
        end
        port0_valid = 1'b0;
        end_op = 1'b1;
        @(posedge clk);
        #1;
        end_op = 1'b0;
        @(negedge clk);
        chk("restart_err", 32'(err), 32'd0);
        chk("restart_cnt", 32'(result_cnt), 32'd4);
        @(posedge clk);
        #1;
        // A result arriving during DRAIN is flagged but still delivered.
        port0_valid = 1'b1;
        port0 = 25'd55;
        exp_q.push_back('{data: 32'd55, user: 1'b0, last: 1'b0});
        @(posedge clk);
        #1;
        port0_valid = 1'b0;
        @(negedge clk);
        chk("err_drain", 32'(err), 32'd1);
        @(posedge clk);
        #1;
        drain(20);
        wait_done(10);
        @(negedge clk);
        chk("err_sticky_end", 32'(err), 32'd1);
        chk("end_cnt", 32'(result_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
